// File: rtl/whack_scorer.sv
// Whack-a-mole scorer: judges debounced presses against the lit-mole mask and keeps a BCD
// score with hit streaks, a double-points bonus, and the best final score of the session.
module whack_scorer #(
  parameter int unsigned HIT_POINTS   = 1,
  parameter int unsigned MISS_PENALTY = 1,
  parameter int unsigned BONUS_STREAK = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        game_active_i,
  input  logic [4:0]  mole_i,
  input  logic [4:0]  whack_i,
  output logic [15:0] score_o,
  output logic [15:0] best_o,
  output logic [3:0]  streak_o,
  output logic        hit_o,
  output logic        miss_o
);

  localparam logic [3:0] HitAdd   = 4'(HIT_POINTS);
  localparam logic [3:0] BonusAdd = 4'(2 * HIT_POINTS);
  localparam logic [3:0] MissSub  = 4'(MISS_PENALTY);
  localparam logic [3:0] BonusLvl = 4'(BONUS_STREAK);

  typedef enum logic [1:0] {StIdle, StPlay, StHold} state_e;

  state_e      state_q, state_d;
  logic        ga_q;
  logic [4:0]  whack_q, mole_q, armed_q, armed_d;
  logic [15:0] score_q, score_d, best_q, best_d;
  logic [3:0]  streak_q, streak_d;
  logic        hit_q, hit_d, miss_q, miss_d;

  logic        rise, fall, eval, mole_chg;
  logic [4:0]  press, armed_eff, hitbits;

  // Decimal add of a small amount; any carry out of the top digit pins the score at 9999.
  function automatic logic [15:0] bcd_add_sat(input logic [15:0] v, input logic [3:0] a);
    logic [4:0]  s, t;
    logic        c;
    logic [15:0] r;
    c = 1'b0;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      s = {1'b0, v[i*4 +: 4]} + {4'd0, c};
      if (i == 0) s = s + {1'b0, a};
      t = s - 5'd10;
      if (s > 5'd9) begin
        r[i*4 +: 4] = t[3:0];
        c = 1'b1;
      end else begin
        r[i*4 +: 4] = s[3:0];
        c = 1'b0;
      end
    end
    return c ? 16'h9999 : r;
  endfunction

  // Decimal subtract; a borrow out of the top digit floors the score at 0000.
  function automatic logic [15:0] bcd_sub_floor(input logic [15:0] v, input logic [3:0] m);
    logic [4:0]  s, t;
    logic        b;
    logic [15:0] r;
    b = 1'b0;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      s = {1'b0, v[i*4 +: 4]} - {4'd0, b};
      if (i == 0) s = s - {1'b0, m};
      t = s + 5'd10;
      if (s[4]) begin
        r[i*4 +: 4] = t[3:0];
        b = 1'b1;
      end else begin
        r[i*4 +: 4] = s[3:0];
        b = 1'b0;
      end
    end
    return b ? 16'h0000 : r;
  endfunction

  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    best_d   = best_q;
    streak_d = streak_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;

    rise      = game_active_i & ~ga_q;
    fall      = ~game_active_i & ga_q;
    press     = whack_i & ~whack_q;
    mole_chg  = (mole_i != mole_q);
    armed_eff = mole_chg ? mole_i : armed_q;
    hitbits   = press & mole_i & armed_eff;
    armed_d   = armed_eff;
    // Requiring ga_q as well drops presses on the game-start cycle.
    eval      = (state_q == StPlay) & game_active_i & ga_q;

    if (eval) begin
      if (|hitbits) begin
        hit_d    = 1'b1;
        armed_d  = armed_eff & ~hitbits;
        score_d  = bcd_add_sat(score_q, (streak_q >= BonusLvl) ? BonusAdd : HitAdd);
        streak_d = (streak_q == 4'hF) ? streak_q : streak_q + 4'd1;
      end else if (|(press & ~mole_i)) begin
        miss_d   = 1'b1;
        score_d  = bcd_sub_floor(score_q, MissSub);
        streak_d = '0;
      end
    end

    case (state_q)
      StIdle, StHold: begin
        if (rise) begin
          state_d  = StPlay;
          score_d  = '0;
          streak_d = '0;
        end
      end
      StPlay: begin
        if (fall) begin
          state_d = StHold;
          // BCD digits order the same as binary, so a plain compare works.
          if (score_q > best_q) best_d = score_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= StIdle;
      ga_q     <= 1'b0;
      whack_q  <= '0;
      mole_q   <= '0;
      armed_q  <= '0;
      score_q  <= '0;
      best_q   <= '0;
      streak_q <= '0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ga_q     <= game_active_i;
      whack_q  <= whack_i;
      mole_q   <= mole_i;
      armed_q  <= armed_d;
      score_q  <= score_d;
      best_q   <= best_d;
      streak_q <= streak_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
    end
  end

  assign score_o  = score_q;
  assign best_o   = best_q;
  assign streak_o = streak_q;
  assign hit_o    = hit_q;
  assign miss_o   = miss_q;

endmodule

// File: tb/tb_whack_scorer.sv
// Self-checking bench for whack_scorer: directed vector table, multi-game sequences,
// randomized play against an integer-arithmetic scoring model, and asynchronous reset.
module tb_whack_scorer;

  localparam int Hit   = 1;
  localparam int Miss  = 1;
  localparam int Bonus = 4;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        game_active_i;
  logic [4:0]  mole_i, whack_i;
  logic [15:0] score_o, best_o;
  logic [3:0]  streak_o;
  logic        hit_o, miss_o;

  always #5 clk_i = ~clk_i;

  whack_scorer #(
    .HIT_POINTS  (Hit),
    .MISS_PENALTY(Miss),
    .BONUS_STREAK(Bonus)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .game_active_i(game_active_i),
    .mole_i       (mole_i),
    .whack_i      (whack_i),
    .score_o      (score_o),
    .best_o       (best_o),
    .streak_o     (streak_o),
    .hit_o        (hit_o),
    .miss_o       (miss_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int rot      = 0;

  // Reference model: 0 idle, 1 playing, 2 holding; score kept as a plain integer.
  int       m_state, m_score, m_best, m_streak;
  bit       m_hit, m_miss, m_ga_q;
  bit [4:0] m_whack_q, m_mole_q, m_armed;

  typedef struct {
    bit          ga;
    bit [4:0]    mole;
    bit [4:0]    whack;
    logic [15:0] score;
    logic [15:0] best;
    logic [3:0]  streak;
    bit          hit;
    bit          miss;
  } vec_t;

  vec_t tbl [0:30];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    m_state = 0; m_score = 0; m_best = 0; m_streak = 0;
    m_hit = 0; m_miss = 0; m_ga_q = 0;
    m_whack_q = '0; m_mole_q = '0; m_armed = '0;
  endtask

  task automatic model_step(input bit ga, input bit [4:0] mole, input bit [4:0] whack);
    bit [4:0] press, live, got;
    press = whack & ~m_whack_q;
    live  = (mole != m_mole_q) ? mole : m_armed;
    got   = press & mole & live;
    m_hit  = 0;
    m_miss = 0;
    if (m_state == 1 && ga && m_ga_q) begin
      if (got != 0) begin
        m_score += (m_streak >= Bonus) ? 2 * Hit : Hit;
        if (m_score > 9999) m_score = 9999;
        if (m_streak < 15) m_streak++;
        live &= ~got;
        m_hit = 1;
      end else if ((press & ~mole) != 0) begin
        m_score -= Miss;
        if (m_score < 0) m_score = 0;
        m_streak = 0;
        m_miss = 1;
      end
    end
    if (m_state != 1 && ga && !m_ga_q) begin
      m_state = 1; m_score = 0; m_streak = 0;
    end else if (m_state == 1 && !ga && m_ga_q) begin
      m_state = 2;
      if (m_score > m_best) m_best = m_score;
    end
    m_ga_q = ga; m_whack_q = whack; m_mole_q = mole; m_armed = live;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".score"},  score_o,            to_bcd(m_score));
    chk({tag, ".best"},   best_o,             to_bcd(m_best));
    chk({tag, ".streak"}, {12'd0, streak_o},  16'(m_streak));
    chk({tag, ".hit"},    {15'd0, hit_o},     16'(m_hit));
    chk({tag, ".miss"},   {15'd0, miss_o},    16'(m_miss));
  endtask

  // Drive one cycle's inputs, advance the model, then sample just after the edge.
  task automatic cycle(input bit ga, input bit [4:0] mole, input bit [4:0] whack);
    game_active_i = ga;
    mole_i        = mole;
    whack_i       = whack;
    model_step(ga, mole, whack);
    @(posedge clk_i);
    #1;
  endtask

  task automatic hit_once();
    bit [4:0] p;
    p = 5'(1 << (rot % 5));
    rot++;
    if (p == mole_i) begin
      p = 5'(1 << (rot % 5));
      rot++;
    end
    cycle(1'b1, p, p);
    check_model("hit");
    cycle(1'b1, p, 5'd0);
    check_model("hit_rel");
  endtask

  task automatic play_game(input int n, input logic [15:0] exp_final);
    cycle(1'b1, mole_i, 5'd0);
    check_model("start");
    chk("start.score", score_o, 16'h0000);
    for (int i = 0; i < n; i++) hit_once();
    cycle(1'b0, mole_i, 5'd0);
    check_model("end");
    chk("final_score", score_o, exp_final);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 5'b00000, 5'b00000, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 5'b00100, 5'b00000, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 5'b00100, 5'b00100, 16'h0001, 16'h0000, 4'd1, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 5'b00100, 5'b00000, 16'h0001, 16'h0000, 4'd1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 5'b00100, 5'b00100, 16'h0001, 16'h0000, 4'd1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 5'b01000, 5'b00000, 16'h0001, 16'h0000, 4'd1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 5'b01000, 5'b00010, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 5'b01000, 5'b00000, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 5'b01000, 5'b00010, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 5'b01000, 5'b00000, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 5'b00001, 5'b00001, 16'h0001, 16'h0000, 4'd1, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 5'b00001, 5'b00000, 16'h0001, 16'h0000, 4'd1, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 5'b00010, 5'b00010, 16'h0002, 16'h0000, 4'd2, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 5'b00010, 5'b00000, 16'h0002, 16'h0000, 4'd2, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 5'b00100, 5'b00100, 16'h0003, 16'h0000, 4'd3, 1'b1, 1'b0};
    tbl[15] = '{1'b1, 5'b00100, 5'b00000, 16'h0003, 16'h0000, 4'd3, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 5'b01000, 5'b01000, 16'h0004, 16'h0000, 4'd4, 1'b1, 1'b0};
    tbl[17] = '{1'b1, 5'b01000, 5'b00000, 16'h0004, 16'h0000, 4'd4, 1'b0, 1'b0};
    tbl[18] = '{1'b1, 5'b10000, 5'b10000, 16'h0006, 16'h0000, 4'd5, 1'b1, 1'b0};
    tbl[19] = '{1'b1, 5'b10000, 5'b00000, 16'h0006, 16'h0000, 4'd5, 1'b0, 1'b0};
    tbl[20] = '{1'b1, 5'b00001, 5'b00001, 16'h0008, 16'h0000, 4'd6, 1'b1, 1'b0};
    tbl[21] = '{1'b1, 5'b00001, 5'b00000, 16'h0008, 16'h0000, 4'd6, 1'b0, 1'b0};
    tbl[22] = '{1'b1, 5'b00010, 5'b00000, 16'h0008, 16'h0000, 4'd6, 1'b0, 1'b0};
    tbl[23] = '{1'b1, 5'b00001, 5'b10001, 16'h0010, 16'h0000, 4'd7, 1'b1, 1'b0};
    tbl[24] = '{1'b1, 5'b00001, 5'b00000, 16'h0010, 16'h0000, 4'd7, 1'b0, 1'b0};
    tbl[25] = '{1'b0, 5'b00001, 5'b00000, 16'h0010, 16'h0010, 4'd7, 1'b0, 1'b0};
    tbl[26] = '{1'b0, 5'b00001, 5'b00001, 16'h0010, 16'h0010, 4'd7, 1'b0, 1'b0};
    tbl[27] = '{1'b0, 5'b00001, 5'b00000, 16'h0010, 16'h0010, 4'd7, 1'b0, 1'b0};
    tbl[28] = '{1'b1, 5'b00010, 5'b00010, 16'h0000, 16'h0010, 4'd0, 1'b0, 1'b0};
    tbl[29] = '{1'b1, 5'b00010, 5'b00000, 16'h0000, 16'h0010, 4'd0, 1'b0, 1'b0};
    tbl[30] = '{1'b1, 5'b00010, 5'b00010, 16'h0001, 16'h0010, 4'd1, 1'b1, 1'b0};

    reset_i = 1'b0;
    game_active_i = 1'b0;
    mole_i = '0;
    whack_i = '0;
    model_reset();
    #12;
    chk("rst.score",  score_o,           16'h0000);
    chk("rst.best",   best_o,            16'h0000);
    chk("rst.streak", {12'd0, streak_o}, 16'h0000);
    chk("rst.hit",    {15'd0, hit_o},    16'h0000);
    chk("rst.miss",   {15'd0, miss_o},   16'h0000);
    reset_i = 1'b1;
    cycle(1'b0, 5'd0, 5'd0);

    for (int i = 0; i < 31; i++) begin
      cycle(tbl[i].ga, tbl[i].mole, tbl[i].whack);
      chk($sformatf("vec%0d.score", i),  score_o,           tbl[i].score);
      chk($sformatf("vec%0d.best", i),   best_o,            tbl[i].best);
      chk($sformatf("vec%0d.streak", i), {12'd0, streak_o}, {12'd0, tbl[i].streak});
      chk($sformatf("vec%0d.hit", i),    {15'd0, hit_o},    {15'd0, tbl[i].hit});
      chk($sformatf("vec%0d.miss", i),   {15'd0, miss_o},   {15'd0, tbl[i].miss});
    end

    // Multi-game best-score tracking; 23/17/27 hits with the bonus give 42/30/50.
    cycle(1'b0, mole_i, 5'd0);
    check_model("close");
    play_game(23, 16'h0042);
    chk("best42", best_o, 16'h0042);
    cycle(1'b0, 5'b00100, 5'b00100);
    check_model("hold_press");
    chk("hold.hit", {15'd0, hit_o}, 16'h0000);
    cycle(1'b0, 5'b00100, 5'b00000);
    chk("hold.score", score_o, 16'h0042);
    play_game(17, 16'h0030);
    chk("best_keep42", best_o, 16'h0042);
    play_game(27, 16'h0050);
    chk("best50", best_o, 16'h0050);

    // 5001 hits land on 9998; the rest must saturate at 9999.
    play_game(5010, 16'h9999);
    chk("best9999", best_o, 16'h9999);

    // Randomized play against the model.
    begin
      bit       ga;
      bit [4:0] mole, whack;
      ga = 1'b0;
      mole = mole_i;
      whack = 5'd0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 99) == 0) ga = ~ga;
        if ($urandom_range(0, 5) == 0) mole = 5'($urandom);
        case ($urandom_range(0, 3))
          0: whack = 5'($urandom);
          1: whack = mole;
          2: whack = 5'd0;
          default: ;
        endcase
        cycle(ga, mole, whack);
        check_model("rand");
      end
    end

    // Asynchronous reset in the middle of a game.
    cycle(1'b0, mole_i, 5'd0);
    play_game(0, 16'h0000);
    cycle(1'b1, mole_i, 5'd0);
    for (int i = 0; i < 6; i++) hit_once();
    chk("pre_rst.score", score_o, 16'h0008);
    #2;
    reset_i = 1'b0;
    game_active_i = 1'b0;
    mole_i = '0;
    whack_i = '0;
    #1;
    chk("arst.score",  score_o,           16'h0000);
    chk("arst.best",   best_o,            16'h0000);
    chk("arst.streak", {12'd0, streak_o}, 16'h0000);
    chk("arst.hit",    {15'd0, hit_o},    16'h0000);
    chk("arst.miss",   {15'd0, miss_o},   16'h0000);
    model_reset();
    @(negedge clk_i);
    reset_i = 1'b1;
    cycle(1'b0, 5'd0, 5'd0);
    check_model("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
